// File: rtl/ope_pkg.sv
// Shared constants and types for the modular-exponentiation datapath stages.
package ope_pkg;

  localparam int WIDTH  = 32;
  localparam int DIGIT  = 8;
  localparam int NDIG   = WIDTH / DIGIT;
  localparam int NSTEP  = NDIG * NDIG;
  localparam int IDX_W  = $clog2(NDIG);
  localparam int CNT_W  = $clog2(NSTEP);
  localparam int PROD_W = 2 * WIDTH;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Low bits of the step count pick the multiplicand digit, high bits the multiplier digit.
  function automatic logic [IDX_W-1:0] digitIdxA(input logic [CNT_W-1:0] cnt);
    return cnt[IDX_W-1:0];
  endfunction

  function automatic logic [IDX_W-1:0] digitIdxB(input logic [CNT_W-1:0] cnt);
    return cnt[CNT_W-1:IDX_W];
  endfunction

  function automatic logic [DIGIT-1:0] getDigit(input logic [WIDTH-1:0] word,
                                                input logic [IDX_W-1:0] idx);
    return word[idx*DIGIT +: DIGIT];
  endfunction

endpackage

// File: rtl/mul_8.sv
// Combinational 8x8 -> 16-bit unsigned digit multiplier.
module mul_8
  import ope_pkg::*;
(
  input  logic [DIGIT-1:0]   a_i,
  input  logic [DIGIT-1:0]   b_i,
  output logic [2*DIGIT-1:0] p_o
);

  assign p_o = (2*DIGIT)'(a_i) * (2*DIGIT)'(b_i);

endmodule

// File: rtl/mul_32.sv
// Digit-serial 32x32 -> 64-bit unsigned multiplier: one 8x8 partial product per clock.
module mul_32
  import ope_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [WIDTH-1:0]  ina,
  input  logic [WIDTH-1:0]  inb,
  output logic              busy,
  output logic              done,
  output logic [PROD_W-1:0] result
);

  state_e              state_q, state_d;
  logic [WIDTH-1:0]    rega_q, rega_d;
  logic [WIDTH-1:0]    regb_q, regb_d;
  logic [PROD_W-1:0]   acc_q, acc_d;
  logic [PROD_W-1:0]   result_q, result_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                done_q, done_d;

  logic [IDX_W-1:0]    idxA, idxB;
  logic [2*DIGIT-1:0]  partial;
  logic [IDX_W:0]      digitSum;
  logic [5:0]          shamt;
  logic [PROD_W-1:0]   term;
  logic                lastStep;

  assign idxA     = digitIdxA(cnt_q);
  assign idxB     = digitIdxB(cnt_q);
  assign digitSum = {1'b0, idxA} + {1'b0, idxB};
  assign shamt    = {digitSum, 3'b000};
  assign lastStep = (cnt_q == CNT_W'(NSTEP - 1));

  mul_8 uDigitMul (
    .a_i (getDigit(rega_q, idxA)),
    .b_i (getDigit(regb_q, idxB)),
    .p_o (partial)
  );

  assign term = PROD_W'(partial) << shamt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      rega_q   <= '0;
      regb_q   <= '0;
      acc_q    <= '0;
      result_q <= '0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rega_q   <= rega_d;
      regb_q   <= regb_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start) state_d = RUN;
      RUN:  if (lastStep) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operand latch and shift/accumulate; done is a one-cycle pulse by defaulting low.
  always_comb begin
    rega_d   = rega_q;
    regb_d   = regb_q;
    acc_d    = acc_q;
    result_d = result_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          rega_d = ina;
          regb_d = inb;
          acc_d  = '0;
          cnt_d  = '0;
        end
      end
      RUN: begin
        acc_d = acc_q + term;
        if (lastStep) begin
          result_d = acc_q + term;
          done_d   = 1'b1;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    busy   = (state_q == RUN);
    done   = done_q;
    result = result_q;
  end

endmodule

// File: tb/tb_mul_32.sv
// Directed self-checking bench for the digit-serial 32x32 multiplier.
module tb_mul_32;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] ina, inb;
  logic        busy, done;
  logic [63:0] result;

  int checks   = 0;
  int failures = 0;
  int lat;
  int doneCount;

  mul_32 dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .ina    (ina),
    .inb    (inb),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic s);
    ina   = a;
    inb   = b;
    start = s;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Waits (bounded) for done; busy must stay high and result must hold its old value until then.
  task automatic waitDone(input int already, input logic [63:0] holdVal, output int latency);
    int busyBad = 0;
    int holdBad = 0;
    latency = already;
    while (latency < 40) begin
      tick();
      latency++;
      if (done === 1'b1) break;
      if (busy !== 1'b1) busyBad++;
      if (result !== holdVal) holdBad++;
    end
    checkOutput("busy_during_run", 64'(busyBad), 64'd0);
    checkOutput("result_held_during_run", 64'(holdBad), 64'd0);
  endtask

  task automatic runOp(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] prevVal, input logic [63:0] expVal);
    applyStimulus(a, b, 1'b1);
    tick();
    applyStimulus(32'hDEAD_BEEF, 32'hCAFE_F00D, 1'b0);
    checkOutput({tag, "_busy_after_accept"}, 64'(busy), 64'd1);
    waitDone(0, prevVal, lat);
    checkOutput({tag, "_latency"}, 64'(lat), 64'd16);
    checkOutput({tag, "_result"}, result, expVal);
    checkOutput({tag, "_busy_in_done_cycle"}, 64'(busy), 64'd0);
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(32'd0, 32'd0, 1'b0);
    tick();
    tick();
    rst = 1'b0;
    checkOutput("reset_busy", 64'(busy), 64'd0);
    checkOutput("reset_done", 64'(done), 64'd0);
    checkOutput("reset_result", result, 64'd0);

    runOp("small", 32'd3, 32'd5, 64'd0, 64'h0000_0000_0000_000F);
    tick();
    checkOutput("small_done_pulse_drops", 64'(done), 64'd0);
    checkOutput("small_result_held_idle", result, 64'h0000_0000_0000_000F);

    runOp("max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_000F,
          64'hFFFF_FFFE_0000_0001);
    tick();

    runOp("shift16", 32'h0001_0000, 32'h0001_0000, 64'hFFFF_FFFE_0000_0001,
          64'h0000_0001_0000_0000);
    tick();
    runOp("topbit", 32'h8000_0000, 32'd2, 64'h0000_0001_0000_0000,
          64'h0000_0001_0000_0000);
    tick();

    // A second start while busy must not disturb the operation in flight.
    applyStimulus(32'd7, 32'd9, 1'b1);
    tick();
    applyStimulus(32'd7, 32'd9, 1'b0);
    repeat (4) tick();
    applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    tick();
    applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    waitDone(5, 64'h0000_0001_0000_0000, lat);
    checkOutput("ignore_start_latency", 64'(lat), 64'd16);
    checkOutput("ignore_start_result", result, 64'h0000_0000_0000_003F);
    tick();
    checkOutput("ignore_start_no_second_run", 64'(busy), 64'd0);

    runOp("zero", 32'd0, 32'h1234_5678, 64'h0000_0000_0000_003F, 64'd0);
    tick();
    checkOutput("zero_done_drops", 64'(done), 64'd0);

    // Reset partway through an operation discards it.
    runOp("prime", 32'd5, 32'd5, 64'd0, 64'd25);
    tick();
    applyStimulus(32'h12, 32'h34, 1'b1);
    tick();
    applyStimulus(32'h12, 32'h34, 1'b0);
    repeat (7) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("midreset_busy", 64'(busy), 64'd0);
    checkOutput("midreset_done", 64'(done), 64'd0);
    checkOutput("midreset_result", result, 64'd0);
    doneCount = 0;
    repeat (20) begin
      tick();
      if (done === 1'b1) doneCount++;
    end
    checkOutput("midreset_no_done", 64'(doneCount), 64'd0);

    runOp("after_reset", 32'd2, 32'd4, 64'd0, 64'd8);
    // Start held in the done cycle is accepted immediately.
    runOp("back_to_back", 32'h100, 32'h100, 64'd8, 64'h0000_0000_0001_0000);
    tick();
    checkOutput("back_to_back_idle", 64'(busy), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
